// File: rtl/mouse_bus_peripheral.sv
// mouse_bus_peripheral: queues mouse samples in a FIFO and serves them to the CPU bus with an interrupt handshake.
module mouse_bus_peripheral #(
   parameter logic [7:0] BASE_ADDR = 8'hA0,
   parameter int         FIFO_AW   = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SAMPLE_VALID,
   input  logic [3:0] MOUSE_STATUS,
   input  logic [7:0] MOUSE_X,
   input  logic [7:0] MOUSE_Y,
   input  logic [7:0] MOUSE_Z,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [7:0] BUS_DATA_IN,
   output logic [7:0] BUS_DATA_OUT,
   output logic       BUS_DATA_OE,
   output logic       BUS_INTERRUPT_RAISE,
   input  logic       BUS_INTERRUPT_ACK
);
   localparam int                 DEPTH    = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, RAISED, SERVICE} state_t;
   state_t             state_q;
   logic [27:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_q, rd_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               ovf_q, raise_q, oe_q;
   logic [7:0]         dout_q, rdata, off;
   logic [27:0]        head;
   logic               empty, full, pop_req, do_pop, do_push, read_req, ovf_set, ovf_clr;
   assign off      = BUS_ADDR - BASE_ADDR;
   assign empty    = count_q == '0;
   assign full     = count_q == FULL_CNT;
   assign pop_req  = BUS_WE && off == 8'd5;
   assign do_pop   = pop_req && !empty;
   // a pop in the same cycle frees the slot a full-FIFO push needs
   assign do_push  = SAMPLE_VALID && (!full || do_pop);
   assign ovf_set  = SAMPLE_VALID && !do_push;
   assign ovf_clr  = BUS_WE && off == 8'd6 && BUS_DATA_IN[0];
   assign read_req = !BUS_WE && off < 8'd5;
   assign count_d  = count_q + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
   assign head     = empty ? '0 : mem_q[rd_q];
   always_comb begin
      rdata = off == 8'd0 ? {4'b0, head[27:24]} :
              off == 8'd1 ? head[23:16] :
              off == 8'd2 ? head[15:8] :
              off == 8'd3 ? head[7:0] :
                            {ovf_q, 3'b0, 4'(count_q)};
   end
   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_q] <= {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z};
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         oe_q    <= 1'b0;
         dout_q  <= '0;
         raise_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         if (do_push) wr_q <= wr_q + FIFO_AW'(1);
         if (do_pop) rd_q <= rd_q + FIFO_AW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_set || (ovf_q && !ovf_clr);
         oe_q    <= read_req;
         dout_q  <= read_req ? rdata : '0;
         case (state_q)
            IDLE: if (count_q != '0) begin
               state_q <= RAISED;
               raise_q <= 1'b1;
            end
            RAISED: if (count_d == '0) begin
               state_q <= IDLE;
               raise_q <= 1'b0;
            end else if (BUS_INTERRUPT_ACK) begin
               state_q <= SERVICE;
               raise_q <= 1'b0;
            end
            SERVICE: if (pop_req) state_q <= IDLE;
            default: begin
               state_q <= IDLE;
               raise_q <= 1'b0;
            end
         endcase
      end
   end
   assign BUS_DATA_OUT        = dout_q;
   assign BUS_DATA_OE         = oe_q;
   assign BUS_INTERRUPT_RAISE = raise_q;
endmodule

// File: tb/tb_mouse_bus_peripheral.sv
// tb_mouse_bus_peripheral: directed scenarios for the mouse FIFO, register map and interrupt handshake.
module tb_mouse_bus_peripheral;
   logic       CLK = 1'b0, RESET = 1'b0, SAMPLE_VALID = 1'b0, BUS_WE = 1'b0, BUS_INTERRUPT_ACK = 1'b0;
   logic [3:0] MOUSE_STATUS = '0;
   logic [7:0] MOUSE_X = '0, MOUSE_Y = '0, MOUSE_Z = '0, BUS_ADDR = '0, BUS_DATA_IN = '0;
   logic [7:0] BUS_DATA_OUT;
   logic       BUS_DATA_OE, BUS_INTERRUPT_RAISE;
   int checks = 0, errors = 0;
   mouse_bus_peripheral dut (
      .CLK(CLK), .RESET(RESET), .SAMPLE_VALID(SAMPLE_VALID), .MOUSE_STATUS(MOUSE_STATUS),
      .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_Z(MOUSE_Z), .BUS_ADDR(BUS_ADDR),
      .BUS_WE(BUS_WE), .BUS_DATA_IN(BUS_DATA_IN), .BUS_DATA_OUT(BUS_DATA_OUT),
      .BUS_DATA_OE(BUS_DATA_OE), .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
      .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK)
   );
   always #5 CLK = ~CLK;
   task automatic tick;
      @(posedge CLK);
      #1;
   endtask
   task automatic do_reset;
      SAMPLE_VALID = 1'b0; BUS_WE = 1'b0; BUS_INTERRUPT_ACK = 1'b0; BUS_ADDR = 8'h00;
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
   endtask
   task automatic push(input logic [27:0] e);
      SAMPLE_VALID = 1'b1;
      {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z} = e;
      tick();
      SAMPLE_VALID = 1'b0;
   endtask
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      BUS_ADDR = a; BUS_WE = 1'b1; BUS_DATA_IN = d;
      tick();
      BUS_WE = 1'b0; BUS_ADDR = 8'h00;
   endtask
   task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
      BUS_ADDR = a; BUS_WE = 1'b0;
      tick();
      d = BUS_DATA_OUT; oe = BUS_DATA_OE;
      BUS_ADDR = 8'h00;
   endtask
   function automatic logic [7:0] field(input logic [27:0] e, input int o);
      return o == 0 ? {4'b0, e[27:24]} : o == 1 ? e[23:16] : o == 2 ? e[15:8] : e[7:0];
   endfunction
   task automatic test_reset;
      do_reset();
      #1;
      checks++;
      if ({BUS_INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT} !== 10'd0) begin
         errors++; $display("FAIL reset_outputs: got %h want 000", {BUS_INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT});
      end
   endtask
   task automatic test_single_sample;
      logic [7:0] d; logic oe;
      do_reset();
      push({4'h9, 8'h50, 8'h3C, 8'h7F});
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t1_raise_early: got %b want 0", BUS_INTERRUPT_RAISE); end
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b1) begin errors++; $display("FAIL t1_raise: got %b want 1", BUS_INTERRUPT_RAISE); end
      rd(8'hA1, d, oe);
      checks++;
      if ({oe, d} !== {1'b1, 8'h50}) begin errors++; $display("FAIL t1_read_x: got oe=%b %h want oe=1 50", oe, d); end
      tick();
      checks++;
      if ({BUS_DATA_OE, BUS_DATA_OUT} !== 9'd0) begin errors++; $display("FAIL t1_oe_drop: got oe=%b %h want oe=0 00", BUS_DATA_OE, BUS_DATA_OUT); end
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h01) begin errors++; $display("FAIL t1_count: got %h want 01", d); end
   endtask
   task automatic test_overflow;
      logic [7:0] d; logic oe; logic [27:0] e;
      do_reset();
      for (int i = 0; i < 5; i++) push({4'(i + 3), 8'(8'h11 * (i + 1)), 8'(8'h20 + i), 8'(8'hF0 - i)});
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h84) begin errors++; $display("FAIL t2_full_ovf: got %h want 84", d); end
      bus_write(8'hA6, 8'h01);
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL t2_ovf_clear: got %h want 04", d); end
      for (int i = 0; i < 4; i++) begin
         e = {4'(i + 3), 8'(8'h11 * (i + 1)), 8'(8'h20 + i), 8'(8'hF0 - i)};
         for (int o = 0; o < 4; o++) begin
            rd(8'(8'hA0 + o), d, oe);
            checks++;
            if (d !== field(e, o)) begin errors++; $display("FAIL t2_entry%0d_off%0d: got %h want %h", i, o, d, field(e, o)); end
         end
         bus_write(8'hA5, 8'h00);
      end
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL t2_drained: got %h want 00", d); end
   endtask
   task automatic test_push_pop_full;
      logic [7:0] d; logic oe;
      do_reset();
      for (int i = 0; i < 4; i++) push({4'(i), 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i)});
      {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z} = {4'hE, 8'hEE, 8'hE1, 8'hE2};
      SAMPLE_VALID = 1'b1;
      bus_write(8'hA5, 8'h00);
      SAMPLE_VALID = 1'b0;
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h04) begin errors++; $display("FAIL t3_count: got %h want 04", d); end
      rd(8'hA1, d, oe);
      checks++;
      if (d !== 8'h41) begin errors++; $display("FAIL t3_head_after_pop: got %h want 41", d); end
      for (int i = 0; i < 3; i++) bus_write(8'hA5, 8'h00);
      rd(8'hA1, d, oe);
      checks++;
      if (d !== 8'hEE) begin errors++; $display("FAIL t3_tail_x: got %h want EE", d); end
      rd(8'hA0, d, oe);
      checks++;
      if (d !== 8'h0E) begin errors++; $display("FAIL t3_tail_status: got %h want 0E", d); end
   endtask
   task automatic test_interrupt;
      logic [7:0] d; logic oe;
      do_reset();
      push(28'h1111111);
      push(28'h2222222);
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b1) begin errors++; $display("FAIL t4_raise: got %b want 1", BUS_INTERRUPT_RAISE); end
      BUS_INTERRUPT_ACK = 1'b1;
      tick();
      BUS_INTERRUPT_ACK = 1'b0;
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t4_ack: got %b want 0", BUS_INTERRUPT_RAISE); end
      push(28'h3333333);
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t4_push_in_service: got %b want 0", BUS_INTERRUPT_RAISE); end
      bus_write(8'hA5, 8'h00);
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t4_pop_idle: got %b want 0", BUS_INTERRUPT_RAISE); end
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b1) begin errors++; $display("FAIL t4_reraise: got %b want 1", BUS_INTERRUPT_RAISE); end
      for (int i = 0; i < 2; i++) begin
         BUS_INTERRUPT_ACK = 1'b1;
         tick();
         BUS_INTERRUPT_ACK = 1'b0;
         bus_write(8'hA5, 8'h00);
         tick();
      end
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t4_final_raise: got %b want 0", BUS_INTERRUPT_RAISE); end
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL t4_final_count: got %h want 00", d); end
   endtask
   task automatic test_pop_in_raised;
      do_reset();
      push(28'h5A5A5A5);
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b1) begin errors++; $display("FAIL tr_raise: got %b want 1", BUS_INTERRUPT_RAISE); end
      bus_write(8'hA5, 8'h00);
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL tr_pop_to_idle: got %b want 0", BUS_INTERRUPT_RAISE); end
   endtask
   task automatic test_empty;
      logic [7:0] d; logic oe;
      do_reset();
      bus_write(8'hA5, 8'h00);
      for (int o = 0; o < 5; o++) begin
         rd(8'(8'hA0 + o), d, oe);
         checks++;
         if ({oe, d} !== {1'b1, 8'h00}) begin errors++; $display("FAIL t5_off%0d: got oe=%b %h want oe=1 00", o, oe, d); end
      end
      rd(8'hA5, d, oe);
      checks++;
      if ({oe, d} !== 9'd0) begin errors++; $display("FAIL t5_wo_read: got oe=%b %h want oe=0 00", oe, d); end
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== 1'b0) begin errors++; $display("FAIL t5_raise: got %b want 0", BUS_INTERRUPT_RAISE); end
   endtask
   task automatic test_reset_midway;
      logic [7:0] d; logic oe;
      do_reset();
      for (int i = 0; i < 3; i++) push(28'(32'h0ABCDEF + i));
      rd(8'hA4, d, oe);
      checks++;
      if ({oe, d, BUS_INTERRUPT_RAISE} !== {1'b1, 8'h03, 1'b1}) begin
         errors++; $display("FAIL t6_before: got oe=%b %h raise=%b want oe=1 03 raise=1", oe, d, BUS_INTERRUPT_RAISE);
      end
      #2 RESET = 1'b0;
      #1;
      checks++;
      if ({BUS_INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT} !== 10'd0) begin
         errors++; $display("FAIL t6_async: got %h want 000", {BUS_INTERRUPT_RAISE, BUS_DATA_OE, BUS_DATA_OUT});
      end
      @(negedge CLK);
      RESET = 1'b1;
      rd(8'hA4, d, oe);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL t6_after: got %h want 00", d); end
   endtask
   initial begin
      test_reset();
      test_single_sample();
      test_overflow();
      test_push_pop_full();
      test_interrupt();
      test_pop_in_raised();
      test_empty();
      test_reset_midway();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
